// File: rtl/mips_run_controller.sv
// ---------------------------------------------------------------------------
// mips_run_controller
//
// Purpose:
//   Turns each rising edge of the divider clock into a single-cycle tick. The
//   tick becomes o_cpu_enable, the only advance strobe for the MIPS pipeline,
//   but only when the run mode allows it. Supported modes are continuous run,
//   single step, stop, and a sticky halt that follows retirement of HALT.
//   The block sits between the clock divider and the pipeline/debug unit.
//
// Configuration:
//   RUN_CONTROL_CYCLE_COUNTER_EN
//     defined   : o_cycle_count counts issued o_cpu_enable pulses and
//                 saturates at all-ones.
//     undefined : no counter is built and o_cycle_count is tied to 0.
//
// Ports:
//   i_clock        system clock
//   i_reset        synchronous, active-high reset
//   i_clock_div    divider output, already in the i_clock domain
//   i_cmd_run      one-cycle pulse: enter continuous run
//   i_cmd_step     one-cycle pulse: execute exactly one cycle
//   i_cmd_stop     one-cycle pulse: stop, or leave HALTED
//   i_halt         CPU retired a HALT instruction
//   o_cpu_enable   pipeline advance strobe, one i_clock cycle wide
//   o_state        0 IDLE, 1 RUN, 2 STEP_WAIT, 3 HALTED
//   o_busy         high while the state is RUN or STEP_WAIT
//   o_cycle_count  number of o_cpu_enable pulses issued
// ---------------------------------------------------------------------------
module mips_run_controller #(
  parameter int NB_CYCLE_COUNT = 32
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_clock_div,
  input  logic                      i_cmd_run,
  input  logic                      i_cmd_step,
  input  logic                      i_cmd_stop,
  input  logic                      i_halt,
  output logic                      o_cpu_enable,
  output logic [1:0]                o_state,
  output logic                      o_busy,
  output logic [NB_CYCLE_COUNT-1:0] o_cycle_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STEP_WAIT = 2'd2,
    HALTED    = 2'd3
  } state_t;

  state_t state;
  state_t next_state;
  logic   div_q;
  logic   tick;
  logic   pulse_next;

  // A tick marks the first i_clock cycle in which the divider output is high.
  assign tick = i_clock_div & ~div_q;

  // Next-state and pulse decision. The commands are resolved in priority
  // order: halt, then stop, then run, then step. A tick only becomes a pulse
  // when the current state consumes it. Halt and stop take precedence over
  // the tick, so a tick in the same cycle as either one is dropped.
  always_comb begin
    next_state = state;
    pulse_next = 1'b0;
    if (i_halt && (state != HALTED)) begin
      next_state = HALTED;
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_stop) begin
            next_state = IDLE;
          end else if (i_cmd_run) begin
            next_state = RUN;
          end else if (i_cmd_step) begin
            next_state = STEP_WAIT;
          end
        end
        RUN: begin
          if (i_cmd_stop) begin
            next_state = IDLE;
          end else begin
            pulse_next = tick;
          end
        end
        STEP_WAIT: begin
          // A run command upgrades the pending step. A tick in that same
          // cycle still produces its one pulse.
          if (i_cmd_stop) begin
            next_state = IDLE;
          end else if (i_cmd_run) begin
            next_state = RUN;
            pulse_next = tick;
          end else if (tick) begin
            next_state = IDLE;
            pulse_next = 1'b1;
          end
        end
        HALTED: begin
          if (i_cmd_stop) begin
            next_state = IDLE;
          end
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // The state, the edge-detect history and the registered outputs are all
  // updated together. o_busy is derived from next_state, so it always agrees
  // with the registered o_state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= IDLE;
      div_q        <= 1'b0;
      o_cpu_enable <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state        <= next_state;
      div_q        <= i_clock_div;
      o_cpu_enable <= pulse_next;
      o_busy       <= (next_state == RUN) || (next_state == STEP_WAIT);
    end
  end

  assign o_state = state;

`ifdef RUN_CONTROL_CYCLE_COUNTER_EN
  // The counter advances on the same edge that raises o_cpu_enable. It holds
  // at all-ones rather than wrapping.
  logic [NB_CYCLE_COUNT-1:0] cycle_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cycle_count <= '0;
    end else if (pulse_next && (cycle_count != {NB_CYCLE_COUNT{1'b1}})) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

  assign o_cycle_count = cycle_count;
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_mips_run_controller.sv
// ---------------------------------------------------------------------------
// tb_mips_run_controller
//
// Directed and randomized checks of mips_run_controller against a behavioural
// model of the run/step/stop/halt rules. The DUT uses a 4-bit counter, so the
// saturation behaviour is exercised when RUN_CONTROL_CYCLE_COUNTER_EN is
// defined.
// ---------------------------------------------------------------------------
module tb_mips_run_controller;

  localparam int NB = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          clock_div = 1'b0;
  logic          cmd_run = 1'b0;
  logic          cmd_step = 1'b0;
  logic          cmd_stop = 1'b0;
  logic          halt = 1'b0;
  logic          cpu_enable;
  logic [1:0]    state;
  logic          busy;
  logic [NB-1:0] cycle_count;

  int compared = 0;
  int mismatched = 0;

  // Model of the expected outputs.
  int          m_mode = 0;
  logic        m_prev_div = 1'b0;
  logic        m_enable = 1'b0;
  int          m_pulses = 0;
  int          div_phase = 0;
  int          pulses_seen = 0;

  mips_run_controller #(.NB_CYCLE_COUNT(NB)) dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_clock_div   (clock_div),
    .i_cmd_run     (cmd_run),
    .i_cmd_step    (cmd_step),
    .i_cmd_stop    (cmd_stop),
    .i_halt        (halt),
    .o_cpu_enable  (cpu_enable),
    .o_state       (state),
    .o_busy        (busy),
    .o_cycle_count (cycle_count)
  );

  always #5 clock = ~clock;

  // Expected counter value: saturating pulse count, or 0 without the counter.
  function automatic logic [NB-1:0] expectedCount();
`ifdef RUN_CONTROL_CYCLE_COUNTER_EN
    int sat;
    sat = (1 << NB) - 1;
    return (m_pulses > sat) ? NB'(sat) : NB'(m_pulses);
`else
    return '0;
`endif
  endfunction

  // Outputs are sampled at the falling edge, half a cycle after the update.
  task automatic checkOutput(input string tag);
    logic [1:0]    exp_state;
    logic          exp_busy;
    logic [NB-1:0] exp_count;
    exp_state = 2'(m_mode);
    exp_busy  = (m_mode == 1) || (m_mode == 2);
    exp_count = expectedCount();
    if (cpu_enable === 1'b1) pulses_seen++;
    compared++;
    assert (cpu_enable === m_enable) else begin
      mismatched++;
      $error("[TB] FAIL %s enable observed=%b expected=%b", tag, cpu_enable, m_enable);
    end
    compared++;
    assert (state === exp_state) else begin
      mismatched++;
      $error("[TB] FAIL %s state observed=%0d expected=%0d", tag, state, exp_state);
    end
    compared++;
    assert (busy === exp_busy) else begin
      mismatched++;
      $error("[TB] FAIL %s busy observed=%b expected=%b", tag, busy, exp_busy);
    end
    compared++;
    assert (cycle_count === exp_count) else begin
      mismatched++;
      $error("[TB] FAIL %s count observed=%0d expected=%0d", tag, cycle_count, exp_count);
    end
  endtask

  // The model applies the rules of one clock edge to the inputs held across it.
  task automatic modelEdge(input logic rst, input logic div, input logic run,
                           input logic step, input logic stop, input logic hlt);
    logic tick;
    logic pulse;
    if (rst) begin
      m_mode = 0; m_prev_div = 1'b0; m_enable = 1'b0; m_pulses = 0;
      return;
    end
    tick = div && !m_prev_div;
    m_prev_div = div;
    pulse = 1'b0;
    if (hlt && m_mode != 3) m_mode = 3;
    else if (m_mode == 0) begin
      if (!stop && run) m_mode = 1;
      else if (!stop && step) m_mode = 2;
    end else if (m_mode == 1) begin
      if (stop) m_mode = 0; else pulse = tick;
    end else if (m_mode == 2) begin
      if (stop) m_mode = 0;
      else if (run) begin m_mode = 1; pulse = tick; end
      else if (tick) begin m_mode = 0; pulse = 1'b1; end
    end else if (stop) m_mode = 0;
    m_enable = pulse;
    if (pulse) m_pulses++;
  endtask

  // One cycle: check the previous edge's result, then drive and predict.
  task automatic driveCycle(input string tag, input logic rst, input logic div,
                            input logic run, input logic step, input logic stop,
                            input logic hlt);
    @(negedge clock);
    checkOutput(tag);
    reset = rst; clock_div = div; cmd_run = run; cmd_step = step;
    cmd_stop = stop; halt = hlt;
    modelEdge(rst, div, run, step, stop, hlt);
  endtask

  // The divider is modelled as high for two cycles of every four.
  task automatic applyStimulus(input string tag, input logic rst, input logic run,
                               input logic step, input logic stop, input logic hlt);
    logic div;
    div = (div_phase >= 2);
    div_phase = (div_phase + 1) % 4;
    driveCycle(tag, rst, div, run, step, stop, hlt);
  endtask

  task automatic idleUntilRise(input string tag);
    while (div_phase != 2) applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int cmd;
    $display("[TB] start");
    // 1. Reset for three cycles.
    for (int i = 0; i < 3; i++) applyStimulus("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // 2. Continuous run over 40 cycles.
    applyStimulus("run_cmd", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulses_seen = 0;
    for (int i = 0; i < 40; i++) applyStimulus("run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // 3. Stop, then a double step before the tick.
    idleUntilRise("pre_stop");
    applyStimulus("stop_tick", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("after_stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("step1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("step2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus("step_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // 4. Halt together with a tick in RUN, then run is ignored and stop releases.
    applyStimulus("run_again", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idleUntilRise("run_idle");
    applyStimulus("halt_tick", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("halted_run", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus("halted", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("halted_stop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // 5. Reset in STEP_WAIT before the tick.
    while (div_phase != 0) applyStimulus("pre_step", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("step_rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("rst_in_step", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Upgrade a pending step to a run in the cycle of a tick.
    applyStimulus("step_up", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idleUntilRise("step_up_wait");
    applyStimulus("run_on_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // 6. Long run for counter saturation.
    for (int i = 0; i < 80; i++) applyStimulus("saturate", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Randomized: random divider level and at most one command per cycle.
    for (int i = 0; i < 600; i++) begin
      cmd = int'($urandom_range(0, 19));
      driveCycle("random", cmd == 0, 1'($urandom_range(0, 1)), cmd == 1 || cmd == 2,
                 cmd == 3 || cmd == 4, cmd == 5, cmd == 6);
    end
    @(negedge clock);
    checkOutput("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
